// File: rtl/ethernet_msg_egress.sv
`default_nettype none
// ============================================================================
//  Module   : ethernet_msg_egress
//  Function : Store-and-forward framer from active-message words to Avalon-ST;
//             only complete, well-framed packets are released to the MAC.
//  Revision : 1.0  initial release
// ============================================================================
module ethernet_msg_egress #(
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_WORDS = 32,
  parameter int AF_THRESH     = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [511:0] msg_data,
  input  logic [31:0]  msg_arg3,
  output logic         msg_almost_full,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         out_sop,
  output logic         out_eop,
  output logic [5:0]   out_empty,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [CW-1:0] C_MAXW  = CW'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IN_PKT  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Storage: payload plus {empty, eop, sop} per word
  logic [511:0] mem_data_q [DEPTH];
  logic [7:0]   mem_ctl_q  [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   pkt_words_q, pkt_words_d;
  logic            out_valid_q, out_valid_d;
  logic [511:0]    out_data_q, out_data_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;
  logic [5:0]      out_empty_q, out_empty_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [31:0]     drop_cnt_q, drop_cnt_d;

  logic            w_sop, w_eop;
  logic [5:0]      w_empty;
  logic [PW-1:0]   w_used, w_free;
  logic            w_has_room, w_accept;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_addr;
  logic [7:0]      w_wr_ctl;
  logic            w_start;
  logic [PW-1:0]   w_start_base;
  logic            w_drop;
  logic            w_load, w_avail;
  logic            unused_arg3;

  assign w_sop       = msg_arg3[0];
  assign w_eop       = msg_arg3[1];
  assign w_empty     = msg_arg3[7:2];
  assign unused_arg3 = ^msg_arg3[31:8];

  assign w_used     = wr_ptr_q - rd_ptr_q;
  assign w_free     = C_DEPTH - w_used;
  assign w_has_room = (w_used < C_DEPTH);
  assign w_accept   = msg_valid && msg_ready;

  assign msg_ready       = (state_q == S_DISCARD) || w_has_room;
  assign msg_almost_full = (32'(w_free) <= 32'(AF_THRESH));

  // Ingress: speculative writes, commit on eop, rollback on framing errors
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pkt_words_d  = pkt_words_q;
    w_wr_en      = 1'b0;
    w_wr_addr    = wr_ptr_q;
    w_wr_ctl     = {(w_eop ? w_empty : 6'd0), w_eop, w_sop};
    w_start      = 1'b0;
    w_start_base = wr_ptr_q;
    w_drop       = 1'b0;

    if (w_accept) begin
      case (state_q)
        S_IDLE: begin
          if (w_sop) begin
            w_start = 1'b1;
          end else begin
            w_drop  = 1'b1;
            state_d = w_eop ? S_IDLE : S_DISCARD;
          end
        end
        S_IN_PKT: begin
          if (w_sop) begin
            // Restart: the new packet overwrites the abandoned fragment
            w_drop       = 1'b1;
            w_start      = 1'b1;
            w_start_base = commit_ptr_q;
          end else if (w_eop) begin
            w_wr_en      = 1'b1;
            wr_ptr_d     = wr_ptr_q + C_ONE;
            commit_ptr_d = wr_ptr_q + C_ONE;
            state_d      = S_IDLE;
          end else if ((pkt_words_q + 1'b1) == C_MAXW) begin
            wr_ptr_d = commit_ptr_q;
            w_drop   = 1'b1;
            state_d  = S_DISCARD;
          end else begin
            w_wr_en     = 1'b1;
            wr_ptr_d    = wr_ptr_q + C_ONE;
            pkt_words_d = pkt_words_q + 1'b1;
          end
        end
        S_DISCARD: begin
          if (w_sop && w_has_room) begin
            w_start = 1'b1;
          end else if (w_sop) begin
            // No space for the new start: it becomes a discarded fragment itself
            w_drop  = 1'b1;
            state_d = w_eop ? S_IDLE : S_DISCARD;
          end else if (w_eop) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (w_start) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_start_base;
      wr_ptr_d  = w_start_base + C_ONE;
      if (w_eop) begin
        commit_ptr_d = w_start_base + C_ONE;
        state_d      = S_IDLE;
      end else begin
        pkt_words_d = CW'(1);
        state_d     = S_IN_PKT;
      end
    end
  end

  // Egress: registered output stage fed only from committed words
  always_comb begin
    w_avail     = (rd_ptr_q != commit_ptr_q);
    w_load      = !out_valid_q || out_ready;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    if (w_load) begin
      out_valid_d = w_avail;
      if (w_avail) begin
        out_data_d  = mem_data_q[rd_ptr_q[AW-1:0]];
        out_sop_d   = mem_ctl_q[rd_ptr_q[AW-1:0]][0];
        out_eop_d   = mem_ctl_q[rd_ptr_q[AW-1:0]][1];
        out_empty_d = mem_ctl_q[rd_ptr_q[AW-1:0]][7:2];
        rd_ptr_d    = rd_ptr_q + C_ONE;
      end
    end
    pkt_cnt_d  = pkt_cnt_q + {31'd0, (out_valid_q && out_ready && out_eop_q)};
    drop_cnt_d = drop_cnt_q + {31'd0, w_drop};
  end

  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      mem_data_q[w_wr_addr[AW-1:0]] <= msg_data;
      mem_ctl_q[w_wr_addr[AW-1:0]]  <= w_wr_ctl;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_words_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_words_q  <= pkt_words_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_msg_egress.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ethernet_msg_egress
//  Function : Self-checking bench for ethernet_msg_egress (small FIFO build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ethernet_msg_egress;

  localparam int DEPTH = 8;
  localparam int MAXW  = 4;
  localparam int AFT   = 2;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         msg_valid, msg_ready, msg_almost_full;
  logic [511:0] msg_data;
  logic [31:0]  msg_arg3;
  logic         out_valid, out_ready, out_sop, out_eop;
  logic [511:0] out_data;
  logic [5:0]   out_empty;
  logic [31:0]  pkt_cnt, drop_cnt;

  ethernet_msg_egress #(.DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW), .AF_THRESH(AFT)) dut (
    .Clk(Clk), .Rst(Rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_arg3(msg_arg3), .msg_almost_full(msg_almost_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   emp;
  } exp_t;

  typedef struct {
    bit       sop;
    bit       eop;
    bit [5:0] emp;
    bit       exp_out;
    int       exp_drop;
  } row_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   tag    = 100;
  int   exp_pkt = 0;

  function automatic logic [511:0] make_data(input int t);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = (32'(t) * 32'h9E37_79B1) ^ 32'(i);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got word sop=%0b eop=%0b data=%h, expected no output",
                   out_sop, out_eop, out_data[31:0]);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_sop !== e.sop || out_eop !== e.eop || out_empty !== e.emp) begin
            errors++;
            $display("FAIL out_word: got sop=%0b eop=%0b empty=%0d data=%h, expected sop=%0b eop=%0b empty=%0d data=%h",
                     out_sop, out_eop, out_empty, out_data[31:0], e.sop, e.eop, e.emp, e.d[31:0]);
          end
        end
      end
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it
  task automatic send(input bit sop, input bit eop, input bit [5:0] emp, input bit exp_out);
    exp_t e;
    bit   ok = 1'b0;
    tag++;
    msg_valid = 1'b1;
    msg_data  = make_data(tag);
    msg_arg3  = {24'hC3A55A, emp, eop, sop};
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (msg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge Clk);
      if (exp_out) begin
        e.d = make_data(tag); e.sop = sop; e.eop = eop; e.emp = eop ? emp : 6'd0;
        sb.push_back(e);
        if (eop) exp_pkt++;
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got msg_ready=0 for 200 cycles, expected 1");
    end
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge Clk); #1;
    end
    check(name, 64'(sb.size()), 0);
    @(posedge Clk); #1;
  endtask

  row_t         tbl [19];
  logic [511:0] exp_w;
  int           k;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    fork run_monitor(); join_none
    msg_valid = 1'b0; msg_data = '0; msg_arg3 = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge Clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_almost_full", msg_almost_full, 0);
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("rst_msg_ready", msg_ready, 1);

    // Single-word packet latency
    send(1, 1, 6'd5, 1);
    check("t1_no_valid_at_T", out_valid, 0);
    @(posedge Clk); #1;
    check("t1_valid_T1", out_valid, 1);
    check("t1_empty", out_empty, 5);
    @(posedge Clk); #1;
    check("t1_pkt_cnt", pkt_cnt, 1);

    // Three-word packet: store and forward, then back-to-back
    send(1, 0, 6'd9, 1); check("t2_hold_w1", out_valid, 0);
    send(0, 0, 6'd9, 1); check("t2_hold_w2", out_valid, 0);
    send(0, 1, 6'd4, 1); check("t2_hold_eop", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("t2_back_to_back", out_valid, 1);
    end
    @(posedge Clk); #1;
    check("t2_pkt_cnt", pkt_cnt, 2);

    // Backpressure mid-packet
    send(1, 0, 6'd0, 1);
    send(0, 0, 6'd0, 1);
    send(0, 1, 6'd11, 1);
    exp_w = make_data(tag - 1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      check("t2_stall_valid", out_valid, 1);
      check("t2_stall_data", out_data[63:0], exp_w[63:0]);
      check("t2_stall_sop", out_sop, 0);
    end
    out_ready = 1'b1;
    wait_drain("t2_drain");
    check("t2_pkt_cnt_stall", pkt_cnt, 3);

    // Framing corner cases: orphan words, restart, oversize, discard exits
    tbl[0]  = '{0, 0, 6'd9, 0, 1};
    tbl[1]  = '{0, 1, 6'd3, 0, 1};
    tbl[2]  = '{1, 0, 6'd9, 0, 1};
    tbl[3]  = '{0, 0, 6'd9, 0, 1};
    tbl[4]  = '{1, 0, 6'd9, 1, 2};
    tbl[5]  = '{0, 0, 6'd9, 1, 2};
    tbl[6]  = '{0, 1, 6'd3, 1, 2};
    tbl[7]  = '{1, 0, 6'd9, 0, 2};
    tbl[8]  = '{0, 0, 6'd9, 0, 2};
    tbl[9]  = '{0, 0, 6'd9, 0, 2};
    tbl[10] = '{0, 0, 6'd9, 0, 3};
    tbl[11] = '{0, 0, 6'd9, 0, 3};
    tbl[12] = '{0, 1, 6'd3, 0, 3};
    tbl[13] = '{1, 1, 6'd7, 1, 3};
    tbl[14] = '{0, 0, 6'd9, 0, 4};
    tbl[15] = '{1, 0, 6'd9, 1, 4};
    tbl[16] = '{0, 1, 6'd2, 1, 4};
    tbl[17] = '{0, 0, 6'd9, 0, 5};
    tbl[18] = '{1, 1, 6'd9, 1, 5};
    for (int r = 0; r < 19; r++) begin
      check($sformatf("tbl%0d_ready", r), msg_ready, 1);
      send(tbl[r].sop, tbl[r].eop, tbl[r].emp, tbl[r].exp_out);
      check($sformatf("tbl%0d_drop", r), drop_cnt, 64'(tbl[r].exp_drop));
    end
    wait_drain("tbl_drain");
    check("tbl_pkt_cnt", pkt_cnt, 64'(exp_pkt));

    // Fill with output stalled; the output register holds the first word
    out_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0, 2, 5, 7: send(1, 0, 6'd0, 0);
        1, 4, 6:    send(0, 1, 6'd1, 0);
        default:    send(0, 0, 6'd0, 0);
      endcase
      k++;
      check($sformatf("t6_af_k%0d", k), msg_almost_full, (k >= 7) ? 1 : 0);
      check($sformatf("t6_ready_k%0d", k), msg_ready, (k < 9) ? 1 : 0);
    end
    msg_valid = 1'b1;
    msg_arg3  = 32'h0;
    repeat (3) @(posedge Clk); #1;
    check("t6_full_blocks", msg_ready, 0);
    check("t6_out_held", out_valid, 1);

    // Reset mid-packet
    #2 Rst = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_pkt_cnt", pkt_cnt, 0);
    check("t6_rst_drop_cnt", drop_cnt, 0);
    check("t6_rst_af", msg_almost_full, 0);
    msg_valid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("t6_post_rst_ready", msg_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge Clk); #1;
    check("t6_no_stale_output", out_valid, 0);
    send(1, 1, 6'd1, 1);
    wait_drain("t6_drain");
    check("t6_pkt_cnt_after", pkt_cnt, 1);
    check("t6_drop_cnt_after", drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
